// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - MMIO controller: address decode, UART handshakes, counters, conv accelerator FSM
module mmio_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    input  logic        inst_retire_i,
    output logic [31:0] rdata_o,
    output logic        io_hit_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_valid_o,
    input  logic        uart_tx_ready_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic        uart_rx_ready_o,
    output logic        conv_start_o,
    input  logic        conv_done_i,
    input  logic [31:0] conv_result_i
);
    localparam logic [31:0] UART_CTRL_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR   = 32'h8000_0008;
    localparam logic [31:0] CYC_CNT_ADDR   = 32'h8000_0010;
    localparam logic [31:0] INST_CNT_ADDR  = 32'h8000_0014;
    localparam logic [31:0] CNT_RST_ADDR   = 32'h8000_0018;
    localparam logic [31:0] CONV_CTRL_ADDR = 32'h8000_0040;
    localparam logic [31:0] CONV_READ_ADDR = 32'h8000_0044;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } conv_state_e;

    conv_state_e state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        io_hit_q, io_hit_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        start_q, start_d;
    logic [31:0] result_q, result_d;

    logic wr_tx, wr_cnt_rst, wr_start, rd_conv_read, rd_rx;
    logic unused_wdata;

    assign unused_wdata = ^wdata_i[31:8];

    assign wr_tx        = wr_en_i && (addr_i == UART_TX_ADDR);
    assign wr_cnt_rst   = wr_en_i && (addr_i == CNT_RST_ADDR);
    assign wr_start     = wr_en_i && (addr_i == CONV_CTRL_ADDR) && wdata_i[0];
    assign rd_conv_read = rd_en_i && (addr_i == CONV_READ_ADDR);
    assign rd_rx        = rd_en_i && (addr_i == UART_RX_ADDR);

    // Pop strobe is combinational so the byte is consumed in the same cycle it is sampled.
    assign uart_rx_ready_o = ~rst & rd_rx & uart_rx_valid_i;

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rdata_d  = rdata_q;
        io_hit_d = io_hit_q;
        if (rd_en_i) begin
            io_hit_d = 1'b1;
            case (addr_i)
                UART_CTRL_ADDR: rdata_d = {30'b0, uart_rx_valid_i, ~tx_valid_q};
                UART_RX_ADDR:   rdata_d = uart_rx_valid_i ? {24'b0, uart_rx_data_i} : 32'b0;
                UART_TX_ADDR:   rdata_d = 32'b0;
                CYC_CNT_ADDR:   rdata_d = cyc_q;
                INST_CNT_ADDR:  rdata_d = inst_q;
                CNT_RST_ADDR:   rdata_d = 32'b0;
                CONV_CTRL_ADDR: rdata_d = {30'b0, state_q == S_DONE, state_q == S_BUSY};
                CONV_READ_ADDR: rdata_d = result_q;
                default: begin
                    rdata_d  = 32'b0;
                    io_hit_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cyc_d      = wr_cnt_rst ? 32'b0 : cyc_q + 32'd1;
        inst_d     = wr_cnt_rst ? 32'b0 : inst_q + {31'b0, inst_retire_i};
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (tx_valid_q) begin
            if (uart_tx_ready_i) tx_valid_d = 1'b0;
        end else if (wr_tx) begin
            tx_data_d  = wdata_i[7:0];
            tx_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (wr_start) begin
                    start_d = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (conv_done_i) begin
                    result_d = conv_result_i;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (wr_start) begin
                    start_d = 1'b1;
                    state_d = S_BUSY;
                end else if (rd_conv_read) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rdata_q    <= 32'b0;
            io_hit_q   <= 1'b0;
            cyc_q      <= 32'b0;
            inst_q     <= 32'b0;
            tx_data_q  <= 8'b0;
            tx_valid_q <= 1'b0;
            start_q    <= 1'b0;
            result_q   <= 32'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            io_hit_q   <= io_hit_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            start_q    <= start_d;
            result_q   <= result_d;
        end
    end

    assign rdata_o         = rdata_q;
    assign io_hit_o        = io_hit_q;
    assign uart_tx_data_o  = tx_data_q;
    assign uart_tx_valid_o = tx_valid_q;
    assign conv_start_o    = start_q;
endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - directed self-checking bench for mmio_ctrl
module tb_mmio_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i, wdata_i, conv_result_i;
    logic        wr_en_i, rd_en_i, inst_retire_i;
    logic [31:0] rdata_o;
    logic        io_hit_o;
    logic [7:0]  uart_tx_data_o, uart_rx_data_i;
    logic        uart_tx_valid_o, uart_tx_ready_i, uart_rx_valid_i, uart_rx_ready_o;
    logic        conv_start_o, conv_done_i;

    int errors = 0;
    int checks = 0;

    mmio_ctrl dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i),
        .wr_en_i(wr_en_i), .rd_en_i(rd_en_i), .inst_retire_i(inst_retire_i),
        .rdata_o(rdata_o), .io_hit_o(io_hit_o),
        .uart_tx_data_o(uart_tx_data_o), .uart_tx_valid_o(uart_tx_valid_o),
        .uart_tx_ready_i(uart_tx_ready_i), .uart_rx_data_i(uart_rx_data_i),
        .uart_rx_valid_i(uart_rx_valid_i), .uart_rx_ready_o(uart_rx_ready_o),
        .conv_start_o(conv_start_o), .conv_done_i(conv_done_i),
        .conv_result_i(conv_result_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        addr_i  = a;
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
        addr_i  = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        wr_en_i = 1'b1;
        @(negedge clk);
        wr_en_i = 1'b0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        addr_i = 0; wdata_i = 0; wr_en_i = 0; rd_en_i = 0; inst_retire_i = 0;
        uart_tx_ready_i = 0; uart_rx_data_i = 0; uart_rx_valid_i = 0;
        conv_done_i = 0; conv_result_i = 0;
        #2;
        check("reset_rdata", rdata_o, 0);
        check("reset_hit", {31'b0, io_hit_o}, 0);
        check("reset_tx_valid", {31'b0, uart_tx_valid_o}, 0);
        check("reset_start", {31'b0, conv_start_o}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // cycle counter: 10 edges after release, captured on the 11th
        repeat (10) @(negedge clk);
        do_read(32'h8000_0010);
        check("cyc_cnt", rdata_o, 10);
        check("cyc_hit", {31'b0, io_hit_o}, 1);

        // instruction counter and counter reset priority
        inst_retire_i = 1'b1;
        repeat (5) @(negedge clk);
        inst_retire_i = 1'b0;
        do_read(32'h8000_0014);
        check("inst_cnt_5", rdata_o, 5);
        inst_retire_i = 1'b1;
        do_write(32'h8000_0018, 32'h0);
        inst_retire_i = 1'b0;
        do_read(32'h8000_0014);
        check("inst_after_clr", rdata_o, 0);
        do_read(32'h8000_0010);
        check("cyc_after_clr", rdata_o, 1);
        inst_retire_i = 1'b1;
        repeat (3) @(negedge clk);
        inst_retire_i = 1'b0;
        do_read(32'h8000_0014);
        check("inst_cnt_3", rdata_o, 3);

        // UART TX one-entry buffer
        do_write(32'h8000_0008, 32'h0000_0141);
        check("tx_valid_set", {31'b0, uart_tx_valid_o}, 1);
        check("tx_data_41", {24'b0, uart_tx_data_o}, 32'h41);
        do_write(32'h8000_0008, 32'h42);
        check("tx_data_kept", {24'b0, uart_tx_data_o}, 32'h41);
        do_read(32'h8000_0000);
        check("status_tx_busy", rdata_o, 0);
        uart_tx_ready_i = 1'b1;
        @(negedge clk);
        uart_tx_ready_i = 1'b0;
        check("tx_valid_clr", {31'b0, uart_tx_valid_o}, 0);
        do_read(32'h8000_0000);
        check("status_tx_ready", rdata_o, 1);

        // UART RX pop
        uart_rx_valid_i = 1'b1;
        uart_rx_data_i  = 8'h5A;
        do_read(32'h8000_0000);
        check("status_rx_valid", rdata_o, 3);
        addr_i  = 32'h8000_0004;
        rd_en_i = 1'b1;
        #1;
        check("rx_ready_pulse", {31'b0, uart_rx_ready_o}, 1);
        @(negedge clk);
        rd_en_i = 1'b0;
        addr_i  = 32'h0;
        uart_rx_valid_i = 1'b0;
        #1;
        check("rx_ready_low", {31'b0, uart_rx_ready_o}, 0);
        check("rx_data", rdata_o, 32'h5A);
        addr_i  = 32'h8000_0004;
        rd_en_i = 1'b1;
        #1;
        check("rx_no_pulse", {31'b0, uart_rx_ready_o}, 0);
        @(negedge clk);
        rd_en_i = 1'b0;
        addr_i  = 32'h0;
        check("rx_empty_data", rdata_o, 0);

        // conv accelerator
        do_write(32'h8000_0040, 32'h1);
        check("conv_start_pulse", {31'b0, conv_start_o}, 1);
        do_read(32'h8000_0040);
        check("conv_start_end", {31'b0, conv_start_o}, 0);
        check("conv_busy", rdata_o, 1);
        do_write(32'h8000_0040, 32'h1);
        check("conv_no_restart", {31'b0, conv_start_o}, 0);
        conv_done_i   = 1'b1;
        conv_result_i = 32'hDEAD_BEEF;
        @(negedge clk);
        conv_done_i   = 1'b0;
        conv_result_i = 32'h0;
        do_read(32'h8000_0040);
        check("conv_done", rdata_o, 2);
        do_read(32'h8000_0044);
        check("conv_result", rdata_o, 32'hDEAD_BEEF);
        do_read(32'h8000_0040);
        check("conv_idle", rdata_o, 0);
        conv_done_i   = 1'b1;
        conv_result_i = 32'h1234_5678;
        @(negedge clk);
        conv_done_i   = 1'b0;
        conv_result_i = 32'h0;
        do_read(32'h8000_0044);
        check("conv_done_ignored", rdata_o, 32'hDEAD_BEEF);

        // unmapped read
        do_read(32'h8000_0020);
        check("unmapped_data", rdata_o, 0);
        check("unmapped_hit", {31'b0, io_hit_o}, 0);

        // reset mid-operation
        do_write(32'h8000_0040, 32'h1);
        do_write(32'h8000_0008, 32'h77);
        do_read(32'h8000_0040);
        check("pre_rst_busy", rdata_o, 1);
        check("pre_rst_tx", {31'b0, uart_tx_valid_o}, 1);
        rst = 1'b1;
        #1;
        check("rst_rdata", rdata_o, 0);
        check("rst_hit", {31'b0, io_hit_o}, 0);
        check("rst_tx_valid", {31'b0, uart_tx_valid_o}, 0);
        check("rst_tx_data", {24'b0, uart_tx_data_o}, 0);
        check("rst_start", {31'b0, conv_start_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h8000_0040);
        check("post_rst_conv", rdata_o, 0);
        do_read(32'h8000_0000);
        check("post_rst_uart", rdata_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
